// File: rtl/bid_arbiter_xbar_if.sv
// Bus bundle between the bus-master agents, the bidding arbiter and the slave peripherals.
// The arbiter connects through the slave modport; the agents/peripherals side uses master.
interface bid_arbiter_xbar_if #(
   parameter int unsigned NM       = 4,
   parameter int unsigned NS       = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned BID_W    = 8,
   parameter int unsigned BUDGET_W = 12
);
   logic [NM-1:0]          m_req;
   logic [NM*BID_W-1:0]    m_bid;
   logic [NM*ADDR_W-1:0]   m_addr;
   logic [NM*DATA_W-1:0]   m_wdata;
   logic [NM-1:0]          m_rw;
   logic [NM-1:0]          m_grant;
   logic [NM-1:0]          m_done;
   logic [NM-1:0]          m_err;
   logic [DATA_W-1:0]      m_rdata;
   logic [NS-1:0]          s_sel;
   logic [ADDR_W-1:0]      s_addr;
   logic [DATA_W-1:0]      s_wdata;
   logic                   s_rw;
   logic [NS*DATA_W-1:0]   s_rdata;
   logic [NS-1:0]          s_ready;
   logic [NM*BUDGET_W-1:0] budget;

   modport master (
      output m_req, m_bid, m_addr, m_wdata, m_rw, s_rdata, s_ready,
      input  m_grant, m_done, m_err, m_rdata, s_sel, s_addr, s_wdata, s_rw, budget
   );

   modport slave (
      input  m_req, m_bid, m_addr, m_wdata, m_rw, s_rdata, s_ready,
      output m_grant, m_done, m_err, m_rdata, s_sel, s_addr, s_wdata, s_rw, budget
   );
endinterface

// File: rtl/bid_arbiter_xbar.sv
// N-master / M-slave bidding arbiter: highest affordable bid wins, one transfer at a time,
// per-master budgets debited on award and refilled every INTERVAL cycles.
module bid_arbiter_xbar #(
   parameter int unsigned NM         = 4,
   parameter int unsigned NS         = 4,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned BID_W      = 8,
   parameter int unsigned BUDGET_W   = 12,
   parameter int unsigned MAX_AMOUNT = 1000,
   parameter int unsigned INTERVAL   = 256,
   parameter logic [15:0] BASE_HI    = 16'hFFEF,
   parameter int unsigned TIMEOUT    = 64
) (
   input logic               clk,
   input logic               rst_n,
   bid_arbiter_xbar_if.slave bus
);
   localparam int unsigned WI_W  = (NM > 1) ? $clog2(NM) : 1;
   localparam int unsigned SI_W  = (NS > 1) ? $clog2(NS) : 1;
   localparam int unsigned CNT_W = $clog2(INTERVAL);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [BUDGET_W-1:0] FULL = BUDGET_W'(MAX_AMOUNT);

   typedef enum logic [1:0] {IDLE, XFER, ERR} state_t;

   state_t                 state;
   logic [NM*BUDGET_W-1:0] bud_q;
   logic [CNT_W-1:0]       refill_cnt;
   logic [WI_W-1:0]        rr_ptr;
   logic [WI_W-1:0]        win;
   logic [SI_W-1:0]        slv;
   logic [TO_W-1:0]        wait_cnt;
   logic [NM-1:0]          grant_q, done_q, err_q;
   logic [NS-1:0]          sel_q;
   logic [DATA_W-1:0]      rdata_q, wdata_q;
   logic [ADDR_W-1:0]      addr_q;
   logic                   rw_q;

   logic [NM-1:0]          elig;
   logic                   found;
   logic [WI_W-1:0]        idx, best_idx;
   logic [BID_W-1:0]       best_bid;
   logic [15:0]            win_hi;
   logic [3:0]             win_field;
   logic                   win_valid;
   logic                   wrap;

   for (genvar g = 0; g < NM; g++) begin : g_elig
      assign elig[g] = bus.m_req[g] && (bus.m_bid[g*BID_W +: BID_W] != '0) &&
                       (BUDGET_W'(bus.m_bid[g*BID_W +: BID_W]) <= bud_q[g*BUDGET_W +: BUDGET_W]);
   end

   // Strict '>' while scanning from rr_ptr upward keeps the first tied master.
   always_comb begin
      found    = 1'b0;
      idx      = '0;
      best_idx = '0;
      best_bid = '0;
      for (int unsigned off = 0; off < NM; off++) begin
         idx = WI_W'((32'(rr_ptr) + off) % NM);
         if (elig[idx] && (!found || bus.m_bid[idx*BID_W +: BID_W] > best_bid)) begin
            found    = 1'b1;
            best_idx = idx;
            best_bid = bus.m_bid[idx*BID_W +: BID_W];
         end
      end
      win_hi    = bus.m_addr[best_idx*ADDR_W + 16 +: 16];
      win_field = bus.m_addr[best_idx*ADDR_W + 12 +: 4];
      win_valid = (win_hi == BASE_HI) && (32'(win_field) < NS);
   end

   assign wrap = (refill_cnt == CNT_W'(INTERVAL - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bud_q      <= {NM{FULL}};
         refill_cnt <= '0;
         rr_ptr     <= '0;
         win        <= '0;
         slv        <= '0;
         wait_cnt   <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         err_q      <= '0;
         sel_q      <= '0;
         rdata_q    <= '0;
         wdata_q    <= '0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
      end else begin
         refill_cnt <= wrap ? '0 : refill_cnt + CNT_W'(1);
         if (wrap) bud_q <= {NM{FULL}};

         case (state)
            IDLE: begin
               done_q <= '0;
               err_q  <= '0;
               if (found) begin
                  win     <= best_idx;
                  rr_ptr  <= (32'(best_idx) == NM - 1) ? '0 : best_idx + WI_W'(1);
                  // A winner on the wrap cycle is debited from the refilled amount.
                  bud_q[best_idx*BUDGET_W +: BUDGET_W] <=
                     (wrap ? FULL : bud_q[best_idx*BUDGET_W +: BUDGET_W]) - BUDGET_W'(best_bid);
                  grant_q  <= NM'(1) << best_idx;
                  addr_q   <= bus.m_addr[best_idx*ADDR_W +: ADDR_W];
                  wdata_q  <= bus.m_wdata[best_idx*DATA_W +: DATA_W];
                  rw_q     <= bus.m_rw[best_idx];
                  slv      <= SI_W'(win_field);
                  wait_cnt <= '0;
                  if (win_valid) begin
                     sel_q <= NS'(1) << win_field;
                     state <= XFER;
                  end else begin
                     sel_q <= '0;
                     state <= ERR;
                  end
               end
            end
            XFER: begin
               if (bus.s_ready[slv]) begin
                  done_q  <= NM'(1) << win;
                  grant_q <= '0;
                  sel_q   <= '0;
                  if (!rw_q) rdata_q <= bus.s_rdata[slv*DATA_W +: DATA_W];
                  state   <= IDLE;
               end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                  done_q  <= NM'(1) << win;
                  err_q   <= NM'(1) << win;
                  grant_q <= '0;
                  sel_q   <= '0;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TO_W'(1);
               end
            end
            ERR: begin
               done_q  <= NM'(1) << win;
               err_q   <= NM'(1) << win;
               grant_q <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.m_grant = grant_q;
   assign bus.m_done  = done_q;
   assign bus.m_err   = err_q;
   assign bus.m_rdata = rdata_q;
   assign bus.s_sel   = sel_q;
   assign bus.s_addr  = addr_q;
   assign bus.s_wdata = wdata_q;
   assign bus.s_rw    = rw_q;
   assign bus.budget  = bud_q;
endmodule
